// File: rtl/tape_pkg.sv
// Constants and FSM encoding shared by the tape-RAM reader and writer controllers.
package tape_pkg;

  localparam int unsigned TAPE_ADDR_W     = 7;
  localparam int unsigned TAPE_DATA_W     = 8;
  localparam int unsigned TAPE_LAST_ADDR  = 126;
  localparam logic [7:0]  TAPE_TERM       = 8'h00;
  localparam int unsigned TAPE_RD_LAT_MAX = 3;
  localparam int unsigned TAPE_CNT_W      = $clog2(TAPE_RD_LAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } tape_state_e;

endpackage

// File: rtl/ram_reader_if.sv
// RAM read port plus downstream valid/ready byte stream of the tape reader.
interface ram_reader_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] ram_addr;
  logic              rden;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output ram_addr, rden, dout, dout_valid,
    input  ram_q, dout_ready
  );

  modport slave (
    input  ram_addr, rden, dout, dout_valid,
    output ram_q, dout_ready
  );

endinterface

// File: rtl/ram_reader_edge_detect.sv
// Registered rising-edge detector; rst_val sets the remembered level after reset.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      din_q <= rst_val;
    end else begin
      din_q <= din_d;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/ram_reader.sv
// Tape-RAM reader: walks the RAM from address 0 and streams bytes until the
// terminator or the last address, one valid/ready handshake per byte.
module ram_reader
  import tape_pkg::*;
#(
  parameter int unsigned        ADDR_W    = TAPE_ADDR_W,
  parameter int unsigned        DATA_W    = TAPE_DATA_W,
  parameter int unsigned        RD_LAT    = 1,
  parameter int unsigned        LAST_ADDR = TAPE_LAST_ADDR,
  parameter logic [DATA_W-1:0]  TERM      = DATA_W'(TAPE_TERM),
  parameter bit                 TERM_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ram_reader_if.master        bus,
  output logic                busy,
  output logic                done
);

  tape_state_e            state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [TAPE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   start_rise;

  // Remembered level resets high so a button held through reset is not an edge.
  edge_detect u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .rst_val (1'b1),
    .din     (start),
    .rise    (start_rise)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        state_d = WAIT;
        cnt_d   = TAPE_CNT_W'(RD_LAT);
      end
      WAIT: begin
        // Counter reaching 1 marks the cycle in which ram_q is valid.
        if (cnt_q == TAPE_CNT_W'(1)) begin
          dout_d = bus.ram_q;
          if (TERM_EN && (bus.ram_q == TERM)) begin
            state_d = DONE;
          end else begin
            state_d = PRESENT;
          end
        end else begin
          cnt_d = cnt_q - TAPE_CNT_W'(1);
        end
      end
      PRESENT: begin
        if (bus.dout_ready) begin
          if (addr_q == ADDR_W'(LAST_ADDR)) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_addr   = addr_q;
  assign bus.rden       = (state_q == FETCH);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == PRESENT);
  assign busy           = (state_q == FETCH) || (state_q == WAIT) || (state_q == PRESENT);
  assign done           = (state_q == DONE);

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: three instances cover RD_LAT=1, TERM_EN=0 and RD_LAT=3.
module tb_ram_reader;

  typedef struct packed {
    logic       rden;
    logic       valid;
    logic       busy;
    logic       done;
    logic [6:0] addr;
    logic [7:0] dout;
  } obs_t;

  typedef struct {
    logic start;
    logic ready;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_reader_if #(.ADDR_W(7), .DATA_W(8)) if_a ();
  ram_reader_if #(.ADDR_W(7), .DATA_W(8)) if_b ();
  ram_reader_if #(.ADDR_W(7), .DATA_W(8)) if_c ();

  ram_reader #(.RD_LAT(1), .TERM_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(if_a), .busy(busy_a), .done(done_a));
  ram_reader #(.RD_LAT(1), .TERM_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(if_b), .busy(busy_b), .done(done_b));
  ram_reader #(.RD_LAT(3), .TERM_EN(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bus(if_c), .busy(busy_c), .done(done_c));

  // RAM models; 8'hEE marks a read slot with no rden behind it.
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic [7:0] pa, pb;
  logic [7:0] pc [3];

  always @(posedge clk) begin
    pa    <= if_a.rden ? mem_a[if_a.ram_addr] : 8'hEE;
    pb    <= if_b.rden ? mem_b[if_b.ram_addr] : 8'hEE;
    pc[0] <= if_c.rden ? mem_a[if_c.ram_addr] : 8'hEE;
    pc[1] <= pc[0];
    pc[2] <= pc[1];
  end

  assign if_a.ram_q = pa;
  assign if_b.ram_q = pb;
  assign if_c.ram_q = pc[2];
  assign if_b.dout_ready = 1'b1;
  assign if_c.dout_ready = 1'b1;

  logic [7:0] qa[$], qb[$], qc[$];
  int rd_a = 0, rd_b = 0, rd_c = 0;
  logic [6:0] max_b = '0;

  always @(posedge clk) begin
    if (reset) begin
      if (if_a.dout_valid && if_a.dout_ready) qa.push_back(if_a.dout);
      if (if_b.dout_valid && if_b.dout_ready) qb.push_back(if_b.dout);
      if (if_c.dout_valid && if_c.dout_ready) qc.push_back(if_c.dout);
      if (if_a.rden) rd_a <= rd_a + 1;
      if (if_b.rden) rd_b <= rd_b + 1;
      if (if_c.rden) rd_c <= rd_c + 1;
      if (if_b.ram_addr > max_b) max_b <= if_b.ram_addr;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_q(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) begin
      for (int i = 0; i < got.size(); i++) if (got[i] !== exp[i]) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d bytes (first %0h) expected %0d bytes (first %0h)", nm,
               got.size(), (got.size() > 0) ? got[0] : 8'h00, exp.size(), exp[0]);
    end
  endtask

  function automatic obs_t mk(input logic r, v, b, d, input logic [6:0] a, input logic [7:0] q);
    obs_t o;
    o = {r, v, b, d, a, q};
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(if_a.rden, if_a.dout_valid, busy_a, done_a, if_a.ram_addr, if_a.dout);
  endfunction

  function automatic obs_t obs_c();
    return mk(if_c.rden, if_c.dout_valid, busy_c, done_c, if_c.ram_addr, if_c.dout);
  endfunction

  task automatic wait_done(input int sel, input int limit, input string nm);
    logic d;
    d = 1'b0;
    for (int i = 0; i < limit; i++) begin
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (d) break;
      tick();
    end
    check(nm, 64'(d), 64'(1));
  endtask

  vec_t tbl [14];
  logic [7:0] exp3[$];
  logic [7:0] none[$];

  initial begin
    int r0;
    int qs;
    int bad;

    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'(i) ^ 8'h55;
    end
    mem_a[0] = 8'h41; mem_a[1] = 8'h42; mem_a[2] = 8'h43; mem_a[3] = 8'h00;
    exp3 = {8'h41, 8'h42, 8'h43};

    // cycle 0 is the start-edge cycle; rden, valid, busy, done, addr, dout
    tbl[0]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 7'd0, 8'h00)};
    tbl[1]  = '{1'b1, 1'b1, mk(1, 0, 1, 0, 7'd0, 8'h00)};
    tbl[2]  = '{1'b1, 1'b1, mk(0, 0, 1, 0, 7'd0, 8'h00)};
    tbl[3]  = '{1'b1, 1'b1, mk(0, 1, 1, 0, 7'd0, 8'h41)};
    tbl[4]  = '{1'b1, 1'b1, mk(1, 0, 1, 0, 7'd1, 8'h41)};
    tbl[5]  = '{1'b0, 1'b1, mk(0, 0, 1, 0, 7'd1, 8'h41)};
    tbl[6]  = '{1'b0, 1'b1, mk(0, 1, 1, 0, 7'd1, 8'h42)};
    tbl[7]  = '{1'b0, 1'b1, mk(1, 0, 1, 0, 7'd2, 8'h42)};
    tbl[8]  = '{1'b0, 1'b1, mk(0, 0, 1, 0, 7'd2, 8'h42)};
    tbl[9]  = '{1'b0, 1'b1, mk(0, 1, 1, 0, 7'd2, 8'h43)};
    tbl[10] = '{1'b0, 1'b1, mk(1, 0, 1, 0, 7'd3, 8'h43)};
    tbl[11] = '{1'b0, 1'b1, mk(0, 0, 1, 0, 7'd3, 8'h43)};
    tbl[12] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 7'd3, 8'h00)};
    tbl[13] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 7'd3, 8'h00)};

    if_a.dout_ready = 1'b1;
    tick(3);
    reset = 1'b1;
    check("reset_state_a", 64'(obs_a()), 64'(mk(0, 0, 0, 0, 7'd0, 8'h00)));
    check("reset_state_c", 64'(obs_c()), 64'(mk(0, 0, 0, 0, 7'd0, 8'h00)));
    tick();

    // Basic pass, cycle-accurate
    r0 = rd_a;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick();
      start_a = tbl[k].start;
      if_a.dout_ready = tbl[k].ready;
      check($sformatf("basic_c%0d", k), 64'(obs_a()), 64'(tbl[k].exp));
    end
    check_q("basic_bytes", qa, exp3);
    check("basic_rden_count", 64'(rd_a - r0), 64'(4));

    // Back-pressure on the second byte
    qa.delete(); r0 = rd_a;
    start_a = 1'b1;
    tick(4);
    if_a.dout_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_%0d", i), 64'(obs_a()), 64'(mk(0, 1, 1, 0, 7'd1, 8'h42)));
      tick();
    end
    if_a.dout_ready = 1'b1;
    wait_done(0, 50, "stall_done");
    check_q("stall_bytes", qa, exp3);
    check("stall_rden_count", 64'(rd_a - r0), 64'(4));
    check("stall_addr", 64'(if_a.ram_addr), 64'(3));

    // Start edge while busy is ignored
    qa.delete(); r0 = rd_a;
    start_a = 1'b0; tick();
    start_a = 1'b1; tick(4);
    start_a = 1'b0; tick();
    start_a = 1'b1;
    wait_done(0, 50, "busy_edge_done");
    check_q("busy_edge_bytes", qa, exp3);
    check("busy_edge_rden_count", 64'(rd_a - r0), 64'(4));

    // Start held high through reset does not start a pass
    reset = 1'b0; tick();
    reset = 1'b1;
    r0 = rd_a;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("held_start_%0d", i), 64'(obs_a()), 64'(mk(0, 0, 0, 0, 7'd0, 8'h00)));
      tick();
    end
    check("held_start_no_rden", 64'(rd_a - r0), 64'(0));
    qa.delete();
    start_a = 1'b0; tick();
    start_a = 1'b1;
    wait_done(0, 50, "after_reset_done");
    check_q("after_reset_bytes", qa, exp3);
    start_a = 1'b0; tick();
    start_a = 1'b1; tick();
    check("restart_from_done", 64'(obs_a()), 64'(mk(1, 0, 1, 0, 7'd0, 8'h00)));
    wait_done(0, 50, "restart_done");

    // Reset while presenting a byte
    start_a = 1'b0; tick();
    start_a = 1'b1; tick(3);
    check("pre_abort_present", 64'(obs_a()), 64'(mk(0, 1, 1, 0, 7'd0, 8'h41)));
    reset = 1'b0; tick();
    check("abort_state", 64'(obs_a()), 64'(mk(0, 0, 0, 0, 7'd0, 8'h00)));
    reset = 1'b1;
    r0 = rd_a; qs = qa.size();
    tick(6);
    check("abort_no_rden", 64'(rd_a - r0), 64'(0));
    check("abort_no_bytes", 64'(qa.size()), 64'(qs));
    check("abort_idle", 64'(obs_a()), 64'(mk(0, 0, 0, 0, 7'd0, 8'h00)));

    // TERM_EN=0: full 127-byte walk, 00 at address 0x55 passes through
    start_b = 1'b1;
    wait_done(1, 1000, "full_done");
    check("full_count", 64'(qb.size()), 64'(127));
    bad = 0;
    for (int i = 0; i < qb.size(); i++) if (qb[i] !== (8'(i) ^ 8'h55)) bad++;
    check("full_data_errors", 64'(bad), 64'(0));
    check("full_max_addr", 64'(max_b), 64'(126));
    check("full_final_addr", 64'(if_b.ram_addr), 64'(126));
    check("full_rden_count", 64'(rd_b), 64'(127));
    tick(3);
    check("full_no_more", 64'(qb.size()), 64'(127));

    // RD_LAT=3
    start_c = 1'b1;
    tick();
    check("lat3_c1", 64'(obs_c()), 64'(mk(1, 0, 1, 0, 7'd0, 8'h00)));
    for (int k = 2; k < 5; k++) begin
      tick();
      check($sformatf("lat3_c%0d", k), 64'(obs_c()), 64'(mk(0, 0, 1, 0, 7'd0, 8'h00)));
    end
    tick();
    check("lat3_c5", 64'(obs_c()), 64'(mk(0, 1, 1, 0, 7'd0, 8'h41)));
    wait_done(2, 100, "lat3_done");
    check_q("lat3_bytes", qc, exp3);
    check("lat3_rden_count", 64'(rd_c), 64'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
